// File: rtl/calc_pkg.sv
// Shared calculator definitions: ASCII codes
// and the number-parser state encoding.
package calc_pkg;

  localparam logic [7:0] ASCII_0     = 8'h30;
  localparam logic [7:0] ASCII_9     = 8'h39;
  localparam logic [7:0] ASCII_SP    = 8'h20;
  localparam logic [7:0] ASCII_TAB   = 8'h09;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_MINUS = 8'h2D;
  localparam logic [7:0] ASCII_COMMA = 8'h2C;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SIGN = 2'd1;
  localparam logic [1:0] ACC  = 2'd2;
  localparam logic [1:0] SKIP = 2'd3;

endpackage

// File: rtl/num_char_class.sv
// Byte classifier for the number parser:
// digit / minus / delimiter / end-of-line.
module num_char_class
  import calc_pkg::*;
(
  input  logic [7:0] rx_byte,
  output logic       is_digit,
  output logic       is_minus,
  output logic       is_delim,
  output logic       is_eol,
  output logic [3:0] digit
);

  assign is_digit = (rx_byte >= ASCII_0) &&
                    (rx_byte <= ASCII_9);
  assign is_minus = (rx_byte == ASCII_MINUS);
  assign is_eol   = (rx_byte == ASCII_CR) ||
                    (rx_byte == ASCII_LF);
  assign is_delim = is_eol ||
                    (rx_byte == ASCII_SP) ||
                    (rx_byte == ASCII_TAB) ||
                    (rx_byte == ASCII_COMMA);
  assign digit    = rx_byte[3:0];

endmodule

// File: rtl/uart_num_parser.sv
// UART byte stream -> signed decimal tokens,
// with a single-entry held output slot.
module uart_num_parser
  import calc_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int MAX_DIGITS = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [DATA_W-1:0] num_data,
  output logic              num_valid,
  input  logic              num_ready,
  output logic              num_err,
  output logic              overrun,
  output logic              eol,
  output logic              busy
);

  localparam int AW = DATA_W + 4;
  localparam int CW = $clog2(MAX_DIGITS + 1);

  localparam logic [AW-1:0] POS_LIM =
    {{(AW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic [AW-1:0] NEG_LIM =
    {{(AW-DATA_W){1'b0}}, 1'b1, {(DATA_W-1){1'b0}}};

  logic [1:0]        state_q, state_d;
  logic [AW-1:0]     acc_q, acc_d;
  logic              neg_q, neg_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] num_data_q, num_data_d;
  logic              num_valid_q, num_valid_d;
  logic              num_err_q, num_err_d;
  logic              overrun_q, overrun_d;
  logic              eol_q, eol_d;

  logic          is_digit;
  logic          is_minus;
  logic          is_delim;
  logic          is_eol;
  logic [3:0]    digit;
  logic [AW-1:0] dig_ext;
  logic [AW-1:0] acc_nx;
  logic          ovf;
  logic          emit;
  logic [DATA_W-1:0] mag;
  logic [DATA_W-1:0] emit_val;

  num_char_class u_class (
    .rx_byte  (rx_data),
    .is_digit (is_digit),
    .is_minus (is_minus),
    .is_delim (is_delim),
    .is_eol   (is_eol),
    .digit    (digit)
  );

  assign dig_ext  = {{(AW-4){1'b0}}, digit};
  assign acc_nx   = acc_q * AW'(10) + dig_ext;
  assign ovf      = (cnt_q == CW'(MAX_DIGITS)) ||
                    (neg_q ? (acc_nx > NEG_LIM)
                           : (acc_nx > POS_LIM));
  assign mag      = acc_q[DATA_W-1:0];
  assign emit_val = neg_q ? -mag : mag;

  // Token FSM, accumulator and output slot
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    neg_d       = neg_q;
    cnt_d       = cnt_q;
    num_data_d  = num_data_q;
    num_valid_d = num_valid_q;
    num_err_d   = 1'b0;
    overrun_d   = 1'b0;
    eol_d       = 1'b0;
    emit        = 1'b0;

    if (rx_valid) begin
      eol_d = is_eol;
      case (state_q)
        IDLE: begin
          unique case (1'b1)
            is_digit: begin
              state_d = ACC;
              acc_d   = dig_ext;
              cnt_d   = CW'(1);
            end
            is_minus: begin
              state_d = SIGN;
              neg_d   = 1'b1;
            end
            is_delim: state_d = IDLE;
            default:  state_d = SKIP;
          endcase
        end
        SIGN: begin
          unique case (1'b1)
            is_digit: begin
              state_d = ACC;
              acc_d   = dig_ext;
              cnt_d   = CW'(1);
            end
            is_delim: begin
              state_d   = IDLE;
              num_err_d = 1'b1;
            end
            default: state_d = SKIP;
          endcase
        end
        ACC: begin
          unique case (1'b1)
            is_digit: begin
              if (ovf) begin
                state_d = SKIP;
              end else begin
                acc_d = acc_nx;
                cnt_d = cnt_q + CW'(1);
              end
            end
            is_delim: begin
              state_d = IDLE;
              emit    = 1'b1;
            end
            default: state_d = SKIP;
          endcase
        end
        default: begin
          if (is_delim) begin
            state_d   = IDLE;
            num_err_d = 1'b1;
          end
        end
      endcase
      if (state_d == IDLE) begin
        acc_d = '0;
        neg_d = 1'b0;
        cnt_d = '0;
      end
    end

    if (emit) begin
      if (!num_valid_q || num_ready) begin
        num_data_d  = emit_val;
        num_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (num_valid_q && num_ready) begin
      num_valid_d = 1'b0;
    end

    if (clr) begin
      state_d     = IDLE;
      acc_d       = '0;
      neg_d       = 1'b0;
      cnt_d       = '0;
      num_data_d  = '0;
      num_valid_d = 1'b0;
      num_err_d   = 1'b0;
      overrun_d   = 1'b0;
      eol_d       = 1'b0;
    end
  end

  // State and output registers, sync reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      neg_q       <= 1'b0;
      cnt_q       <= '0;
      num_data_q  <= '0;
      num_valid_q <= 1'b0;
      num_err_q   <= 1'b0;
      overrun_q   <= 1'b0;
      eol_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      neg_q       <= neg_d;
      cnt_q       <= cnt_d;
      num_data_q  <= num_data_d;
      num_valid_q <= num_valid_d;
      num_err_q   <= num_err_d;
      overrun_q   <= overrun_d;
      eol_q       <= eol_d;
    end
  end

  assign num_data  = num_data_q;
  assign num_valid = num_valid_q;
  assign num_err   = num_err_q;
  assign overrun   = overrun_q;
  assign eol       = eol_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_num_parser.sv
// Directed bench for uart_num_parser: string
// vectors plus multi-cycle handshake sequences.
module tb_uart_num_parser;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic [7:0] num_data;
  logic       num_valid;
  logic       num_ready = 1'b1;
  logic       num_err;
  logic       overrun;
  logic       eol;
  logic       busy;

  int n_chk = 0;
  int n_fail = 0;

  int         o_nv, o_ne, o_eol, o_ov;
  logic [7:0] o_dat;

  typedef struct {
    string      s;
    int         nv;
    logic [7:0] dat;
    int         ne;
    int         neol;
  } vec_t;

  vec_t vecs[$];

  uart_num_parser #(.DATA_W(8), .MAX_DIGITS(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .num_data  (num_data),
    .num_valid (num_valid),
    .num_ready (num_ready),
    .num_err   (num_err),
    .overrun   (overrun),
    .eol       (eol),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input int act,
                     input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endtask

  task automatic observe();
    if (num_valid) begin
      o_nv++;
      o_dat = num_data;
    end
    if (num_err) o_ne++;
    if (eol) o_eol++;
    if (overrun) o_ov++;
  endtask

  // Inputs change on negedge; after the call the
  // effect of the byte is visible (one posedge).
  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) @(negedge clk);
  endtask

  task automatic flush();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  initial begin
    vecs.push_back('{"2 3 ",     2, 8'd3,   0, 0});
    vecs.push_back('{"127 ",     1, 8'd127, 0, 0});
    vecs.push_back('{"-128 ",    1, 8'h80,  0, 0});
    vecs.push_back('{"128 ",     0, 8'd0,   1, 0});
    vecs.push_back('{"-129 ",    0, 8'd0,   1, 0});
    vecs.push_back('{"1000 ",    0, 8'd0,   1, 0});
    vecs.push_back('{"1a ",      0, 8'd0,   1, 0});
    vecs.push_back('{"- ",       0, 8'd0,   1, 0});
    vecs.push_back('{"--5 ",     0, 8'd0,   1, 0});
    vecs.push_back('{"   5\r\n", 1, 8'd5,   0, 2});
    vecs.push_back('{"-0 ",      1, 8'd0,   0, 0});
    vecs.push_back('{"007 ",     1, 8'd7,   0, 0});
    vecs.push_back('{"0012 ",    0, 8'd0,   1, 0});
    vecs.push_back('{"-5,6\t",   2, 8'd6,   0, 0});
    vecs.push_back('{"x5 ",      0, 8'd0,   1, 0});
    vecs.push_back('{"12\n",     1, 8'd12,  0, 1});
    vecs.push_back('{"-7 ",      1, 8'hF9,  0, 0});

    // Reset state
    rst_n = 1'b0;
    idle(2);
    chk("rst num_valid", num_valid, 0);
    chk("rst num_data", num_data, 0);
    chk("rst num_err", num_err, 0);
    chk("rst overrun", overrun, 0);
    chk("rst eol", eol, 0);
    chk("rst busy", busy, 0);
    rst_n = 1'b1;
    idle(1);

    // Table-driven token vectors, back-to-back bytes
    foreach (vecs[v]) begin
      flush();
      num_ready = 1'b1;
      o_nv = 0; o_ne = 0; o_eol = 0; o_ov = 0;
      o_dat = 8'hxx;
      for (int i = 0; i < vecs[v].s.len(); i++) begin
        send(vecs[v].s[i]);
        observe();
      end
      for (int k = 0; k < 2; k++) begin
        @(negedge clk);
        observe();
      end
      chk($sformatf("v%0d tokens", v), o_nv, vecs[v].nv);
      chk($sformatf("v%0d errs", v), o_ne, vecs[v].ne);
      chk($sformatf("v%0d eols", v), o_eol, vecs[v].neol);
      chk($sformatf("v%0d overrun", v), o_ov, 0);
      chk($sformatf("v%0d busy", v), busy, 0);
      if (vecs[v].nv > 0)
        chk($sformatf("v%0d data", v), o_dat, vecs[v].dat);
    end

    // Latency: valid exactly one cycle after space
    flush();
    num_ready = 1'b1;
    send("2");
    chk("lat valid early", num_valid, 0);
    chk("lat busy", busy, 1);
    send(" ");
    chk("lat valid", num_valid, 1);
    chk("lat data", num_data, 2);
    idle(1);
    chk("lat valid drop", num_valid, 0);

    // Backpressure and overrun
    flush();
    num_ready = 1'b0;
    send("4");
    send(" ");
    chk("bp valid", num_valid, 1);
    chk("bp data", num_data, 4);
    idle(3);
    chk("bp hold valid", num_valid, 1);
    chk("bp hold data", num_data, 4);
    send("9");
    send(" ");
    chk("ovr pulse", overrun, 1);
    chk("ovr data", num_data, 4);
    chk("ovr valid", num_valid, 1);
    idle(1);
    chk("ovr pulse end", overrun, 0);
    num_ready = 1'b1;
    chk("accept still valid", num_valid, 1);
    idle(1);
    chk("accept drop", num_valid, 0);

    // Accept and emit on the same edge
    flush();
    num_ready = 1'b0;
    send("4");
    send(" ");
    send("6");
    chk("sim pend data", num_data, 4);
    num_ready = 1'b1;
    send(" ");
    chk("sim valid", num_valid, 1);
    chk("sim data", num_data, 6);
    chk("sim no ovr", overrun, 0);
    idle(1);
    chk("sim drop", num_valid, 0);

    // clr drops a pending output
    num_ready = 1'b0;
    send("5");
    send(" ");
    chk("clr pend", num_valid, 1);
    flush();
    chk("clr valid", num_valid, 0);
    chk("clr data", num_data, 0);

    // clr drops a partial token
    num_ready = 1'b1;
    send("4");
    flush();
    chk("clr busy", busy, 0);
    send("7");
    send(" ");
    chk("clr next valid", num_valid, 1);
    chk("clr next data", num_data, 7);
    idle(1);

    // clr wins over a same-cycle delimiter
    send("8");
    clr = 1'b1;
    send("\n");
    clr = 1'b0;
    chk("clr prio valid", num_valid, 0);
    chk("clr prio eol", eol, 0);
    chk("clr prio busy", busy, 0);

    // Reset mid-token
    send("1");
    send("2");
    chk("mid busy", busy, 1);
    rst_n = 1'b0;
    idle(1);
    chk("mid rst busy", busy, 0);
    chk("mid rst valid", num_valid, 0);
    chk("mid rst data", num_data, 0);
    rst_n = 1'b1;
    send("3");
    send(" ");
    chk("post rst valid", num_valid, 1);
    chk("post rst data", num_data, 3);
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
